// File: rtl/sr_cmd_pkg.sv
// Shared types and constants for the SR command generator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
`timescale 1ns/1ps
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int DEF_DB_CYCLES    = 4;
    localparam int DEF_PULSE_LEN    = 1;
    localparam int DEF_GAP_CYCLES   = 2;
    localparam int DEF_CLR_PRIORITY = 1;

    // Bits needed to hold values 0..value-1; never less than one bit so that
    // degenerate parameter choices still yield a legal vector.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Button conditioner: 2-flop synchroniser, stability debounce, rising-edge pulse.
// Latency: level follows raw_in after 2 sync + DB_CYCLES stable cycles; rise is registered with level.
// Backpressure: none; the stage is free-running and cannot stall.
// Ports: clk, reset (async active-low), raw_in (asynchronous button),
//        level (debounced level), rise (one-cycle pulse when level goes 0->1).
`timescale 1ns/1ps
module sr_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic rise
);

    localparam int                CNT_W    = clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            level     <= 1'b0;
            rise      <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= raw_in;
            sync_q    <= sync_meta;
            rise      <= 1'b0;
            if (sync_q != level) begin
                // The DB_CYCLES-th consecutive disagreeing sample commits the new level.
                if (cnt == CNT_LAST) begin
                    level <= sync_q;
                    rise  <= sync_q;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns raw set/clear buttons into clean, mutually exclusive s/r pulses for an SR flip-flop.
// Latency: s/r rise 2 clk after the debounced level rises (edge->pending->pulse) when idle.
// Backpressure: requests arriving while busy are held pending; a repeat while pending is dropped and flags overrun.
// Ports: clk, reset (async active-low), set_btn/clr_btn (raw, async), s/r (registered pulses),
//        busy (state != IDLE), conflict (both pending at arbitration), overrun (sticky drop flag).
`timescale 1ns/1ps
module sr_cmd_gen
    import sr_cmd_pkg::*;
#(
    parameter int DB_CYCLES    = DEF_DB_CYCLES,
    parameter int PULSE_LEN    = DEF_PULSE_LEN,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CLR_PRIORITY = DEF_CLR_PRIORITY
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic overrun
);

    localparam int               TMR_MAX    = (PULSE_LEN > GAP_CYCLES) ? PULSE_LEN : GAP_CYCLES;
    localparam int               TMR_W      = clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic set_level, set_rise;
    logic clr_level, clr_rise;

    state_t           state, state_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic             set_pend, set_pend_nx;
    logic             clr_pend, clr_pend_nx;
    logic             take_set, take_clr;
    logic             conflict_nx;
    logic             overrun_nx;

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk    (clk),
        .reset  (reset),
        .raw_in (set_btn),
        .level  (set_level),
        .rise   (set_rise)
    );

    sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_clr_db (
        .clk    (clk),
        .reset  (reset),
        .raw_in (clr_btn),
        .level  (clr_level),
        .rise   (clr_rise)
    );

    // Debounced levels are only needed inside the conditioner; commands are edge-triggered.
    logic unused_levels;
    assign unused_levels = set_level ^ clr_level;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tmr      <= '0;
            set_pend <= 1'b0;
            clr_pend <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            tmr      <= tmr_nx;
            set_pend <= set_pend_nx;
            clr_pend <= clr_pend_nx;
            // Outputs are registered from the next state so s/r align with the state register
            // and can never both be high.
            s        <= (state_nx == PULSE_S);
            r        <= (state_nx == PULSE_R);
            conflict <= conflict_nx;
            overrun  <= overrun_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tmr_nx      = tmr;
        take_set    = 1'b0;
        take_clr    = 1'b0;
        conflict_nx = 1'b0;
        case (state)
            IDLE: begin
                tmr_nx = '0;
                if (set_pend && clr_pend) begin
                    // Only the winner is served; the loser is discarded, not deferred.
                    conflict_nx = 1'b1;
                    take_set    = 1'b1;
                    take_clr    = 1'b1;
                    state_nx    = (CLR_PRIORITY != 0) ? PULSE_R : PULSE_S;
                end else if (set_pend) begin
                    take_set = 1'b1;
                    state_nx = PULSE_S;
                end else if (clr_pend) begin
                    take_clr = 1'b1;
                    state_nx = PULSE_R;
                end
            end
            PULSE_S, PULSE_R: begin
                if (tmr == PULSE_LAST) begin
                    tmr_nx   = '0;
                    state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            GAP: begin
                if (tmr == GAP_LAST) begin
                    tmr_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    tmr_nx = tmr + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                tmr_nx   = '0;
            end
        endcase

        // An edge landing in the same cycle its flag is being served re-arms the flag
        // rather than counting as an overrun: the earlier request is leaving this cycle.
        set_pend_nx = (set_pend & ~take_set) | set_rise;
        clr_pend_nx = (clr_pend & ~take_clr) | clr_rise;
        overrun_nx  = overrun
                    | (set_rise & set_pend & ~take_set)
                    | (clr_rise & clr_pend & ~take_clr);
    end

    assign busy = (state != IDLE);

endmodule
